seg_shift_driver: RTL and testbench

Drives one digit of the four-digit seven-segment display per refresh slot. It sits directly downstream of the refresh clock and samples its 2-bit digit-select and blank outputs. On every digit-select change it decodes the selected hex nibble and shifts {dp, g..a} MSB-first into the external segment shift register. It then pulses the register latch, updates the anode drive and gates output-enable with blank, all within the 17-cycle load window the refresh clock reserves.

---
 rtl/seg_shift_driver.sv | 158 +++++++++++++++
 tb/tb_seg_shift_driver.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_shift_driver.sv
// Seven-segment digit driver: decodes the selected hex nibble and shifts it into an
// external segment shift register, then latches it and updates the anodes. Define SEG_DP_EN to drive decimal points.
//
// state | meaning
// IDLE  | waiting for a digit_sel change or a pending frame
// SHIFT | clocking 8 bits out, two sysclk phases per bit
// LATCH | one-cycle storage-register latch pulse, anode update
module seg_shift_driver #(
  parameter bit ACTIVE_LOW_SEG = 1'b1,
  parameter bit ACTIVE_LOW_AN  = 1'b1
) (
  input  logic        sysclk,
  input  logic        rst_n,
  input  logic [1:0]  digit_sel,
  input  logic        blank,
  input  logic [15:0] digits,
  input  logic [3:0]  dp,
  output logic        ser_data,
  output logic        ser_clk,
  output logic        ser_latch,
  output logic [3:0]  an,
  output logic        oe_n,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  localparam logic [3:0] AN_OFF = ACTIVE_LOW_AN ? 4'hF : 4'h0;

  state_t     state;
  logic [1:0] sel_q;
  logic [1:0] sel;
  logic       pending;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic       phase;

  logic       change;
  logic       start;
  logic [3:0] nib;
  logic [6:0] seg;
  logic       dp_bit;
  logic [7:0] load_byte;
  logic [3:0] an_onehot;

  assign change = (digit_sel != sel_q);
  assign start  = (state == IDLE) && (change || pending);
  assign nib    = digits[{digit_sel, 2'b00} +: 4];

  always_comb begin
    seg = 7'h00;
    case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end

`ifdef SEG_DP_EN
  assign dp_bit = dp[digit_sel];
`else
  // dp stays on the port for pin compatibility; the bit shifts out as "off".
  logic dp_unused;
  assign dp_unused = ^dp;
  assign dp_bit    = 1'b0;
`endif

  assign load_byte = {dp_bit, seg} ^ {8{ACTIVE_LOW_SEG}};
  assign an_onehot = 4'b0001 << sel;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel_q     <= 2'd0;
      sel       <= 2'd0;
      pending   <= 1'b1;
      shreg     <= 8'h00;
      bit_cnt   <= 3'd0;
      phase     <= 1'b0;
      ser_data  <= 1'b0;
      ser_clk   <= 1'b0;
      ser_latch <= 1'b0;
      an        <= AN_OFF;
      oe_n      <= 1'b1;
      busy      <= 1'b0;
    end else begin
      sel_q <= digit_sel;
      // Any number of mid-frame changes collapse into one follow-up frame.
      if (start)
        pending <= 1'b0;
      else if (change && (state != IDLE))
        pending <= 1'b1;

      case (state)
        IDLE: begin
          ser_latch <= 1'b0;
          ser_clk   <= 1'b0;
          if (start) begin
            state    <= SHIFT;
            sel      <= digit_sel;
            shreg    <= load_byte;
            ser_data <= load_byte[7];
            bit_cnt  <= 3'd0;
            phase    <= 1'b0;
            busy     <= 1'b1;
            oe_n     <= 1'b1;
          end else begin
            busy <= 1'b0;
            oe_n <= blank;
          end
        end
        SHIFT: begin
          busy <= 1'b1;
          oe_n <= 1'b1;
          if (!phase) begin
            ser_clk <= 1'b1;
            phase   <= 1'b1;
          end else begin
            ser_clk <= 1'b0;
            phase   <= 1'b0;
            shreg   <= {shreg[6:0], 1'b0};
            if (bit_cnt == 3'd7) begin
              state     <= LATCH;
              ser_latch <= 1'b1;
              an        <= ACTIVE_LOW_AN ? ~an_onehot : an_onehot;
            end else begin
              bit_cnt  <= bit_cnt + 3'd1;
              ser_data <= shreg[6];
            end
          end
        end
        LATCH: begin
          ser_latch <= 1'b0;
          ser_clk   <= 1'b0;
          state     <= IDLE;
          busy      <= 1'b0;
          oe_n      <= blank;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_shift_driver.sv
// Bench for seg_shift_driver: table of digit frames plus hand sequences for reset,
// collapsed changes, blanking and mid-frame reset. A monitor reassembles shifted bytes.
module tb_seg_shift_driver;

  logic        sysclk = 1'b0;
  logic        rst_n;
  logic [1:0]  digit_sel;
  logic        blank;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic        ser_data, ser_clk, ser_latch, oe_n, busy;
  logic [3:0]  an;

  seg_shift_driver dut (
    .sysclk(sysclk), .rst_n(rst_n), .digit_sel(digit_sel), .blank(blank),
    .digits(digits), .dp(dp), .ser_data(ser_data), .ser_clk(ser_clk),
    .ser_latch(ser_latch), .an(an), .oe_n(oe_n), .busy(busy)
  );

  always #5 sysclk = ~sysclk;

  int total = 0;
  int bad   = 0;

  logic [11:0] exp_q[$];  // {byte, an}
  logic [7:0]  acc;
  int          nbits = 0;
  logic        prev_clk = 1'b0;
  int          latch_cnt = 0;
  int          cyc = 0;
  int          last_latch_cyc = 0;
  int          prev_latch_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  always @(negedge sysclk) begin
    cyc++;
    if (!rst_n) begin
      nbits    = 0;
      prev_clk = 1'b0;
    end else begin
      if (ser_clk && !prev_clk) begin
        acc = {acc[6:0], ser_data};
        nbits++;
      end
      prev_clk = ser_clk;
      if (busy && !oe_n) chk("oe_n_during_frame", oe_n, 1);
      if (ser_latch) begin
        latch_cnt++;
        prev_latch_cyc = last_latch_cyc;
        last_latch_cyc = cyc;
        chk("bits_per_frame", nbits, 8);
        if (exp_q.size() == 0) begin
          chk("unexpected_latch", latch_cnt, 0);
        end else begin
          logic [11:0] e;
          e = exp_q.pop_front();
          chk("shifted_byte", acc, e[11:4]);
          chk("an_at_latch", an, e[3:0]);
        end
        nbits = 0;
      end
    end
  end

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] dig;
    logic [3:0]  dpv;
    logic [7:0]  byte_v;
    logic [3:0]  an_v;
  } vec_t;

  // Counts negedges from the change to the latch pulse; latch at 17, busy low at 18.
  task automatic run_frame(input string name, input logic [1:0] s, input logic [7:0] b,
                           input logic [3:0] a);
    int k;
    exp_q.push_back({b, a});
    digit_sel = s;
    k = 0;
    do begin
      @(negedge sysclk);
      k++;
      if (k == 1) begin
        chk({name, "_busy_rise"}, busy, 1);
        chk({name, "_oe_n_frame"}, oe_n, 1);
      end
    end while (!ser_latch && k < 40);
    chk({name, "_latch_cycle"}, k, 17);
    chk({name, "_busy_at_latch"}, busy, 1);
    @(negedge sysclk);
    chk({name, "_latch_width"}, ser_latch, 0);
    chk({name, "_busy_fall"}, busy, 0);
    chk({name, "_an_final"}, an, a);
  endtask

  vec_t vt[10];

  initial begin
    int base;
    int k;
`ifdef SEG_DP_EN
    vt[0] = '{2'd2, 16'h0A00, 4'b0100, 8'h08, 4'b1011};
    vt[9] = '{2'd0, 16'h0000, 4'hF,    8'h40, 4'b1110};
`else
    vt[0] = '{2'd2, 16'h0A00, 4'b0100, 8'h88, 4'b1011};
    vt[9] = '{2'd0, 16'h0000, 4'hF,    8'hC0, 4'b1110};
`endif
    vt[1] = '{2'd1, 16'h0030, 4'h0, 8'hB0, 4'b1101};
    vt[2] = '{2'd3, 16'h5000, 4'h0, 8'h92, 4'b0111};
    vt[3] = '{2'd0, 16'h0008, 4'h0, 8'h80, 4'b1110};
    vt[4] = '{2'd2, 16'h0F00, 4'h0, 8'h8E, 4'b1011};
    vt[5] = '{2'd1, 16'h00B0, 4'h0, 8'h83, 4'b1101};
    vt[6] = '{2'd3, 16'hE000, 4'h0, 8'h86, 4'b0111};
    vt[7] = '{2'd0, 16'h000D, 4'h0, 8'hA1, 4'b1110};
    vt[8] = '{2'd1, 16'h0020, 4'h0, 8'hA4, 4'b1101};

    rst_n = 1'b0; digit_sel = 2'd0; blank = 1'b0; digits = 16'h0000; dp = 4'h0;
    repeat (3) @(negedge sysclk);
    chk("rst_ser_data", ser_data, 0);
    chk("rst_ser_clk", ser_clk, 0);
    chk("rst_ser_latch", ser_latch, 0);
    chk("rst_an", an, 4'hF);
    chk("rst_oe_n", oe_n, 1);
    chk("rst_busy", busy, 0);

    // First frame after release needs no digit_sel change.
    exp_q.push_back({8'hC0, 4'b1110});
    #2 rst_n = 1'b1;
    k = 0;
    do begin @(negedge sysclk); k++; end while (!ser_latch && k < 40);
    chk("release_latch_cycle", k, 17);
    @(negedge sysclk);
    chk("release_an", an, 4'b1110);
    repeat (2) @(negedge sysclk);

    for (int i = 0; i < 10; i++) begin
      digits = vt[i].dig;
      dp     = vt[i].dpv;
      run_frame($sformatf("vec%0d", i), vt[i].sel, vt[i].byte_v, vt[i].an_v);
      repeat (2) @(negedge sysclk);
    end

    // Changes during a frame collapse into one follow-up frame using the latest sel.
    digits = 16'h7531; dp = 4'h0;
    base = latch_cnt;
    exp_q.push_back({8'hB0, 4'b1101});
    exp_q.push_back({8'hF8, 4'b0111});
    digit_sel = 2'd1;
    repeat (4) @(negedge sysclk);
    digit_sel = 2'd2;
    repeat (4) @(negedge sysclk);
    digit_sel = 2'd3;
    repeat (60) @(negedge sysclk);
    chk("collapse_latch_count", latch_cnt - base, 2);
    chk("collapse_back_to_back", last_latch_cyc - prev_latch_cyc, 18);
    chk("collapse_queue_empty", exp_q.size(), 0);
    chk("collapse_an", an, 4'b0111);

    blank = 1'b1;
    @(negedge sysclk);
    chk("blank_oe_n_high", oe_n, 1);
    blank = 1'b0;
    @(negedge sysclk);
    chk("unblank_oe_n_low", oe_n, 0);

    // Reset at cycle 9 of a frame: asynchronous clear, no latch, full frame on release.
    digits = 16'h0600;
    base = latch_cnt;
    exp_q.push_back({8'h82, 4'b1011});
    digit_sel = 2'd2;
    repeat (9) @(negedge sysclk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_ser_clk", ser_clk, 0);
    chk("midrst_ser_data", ser_data, 0);
    chk("midrst_ser_latch", ser_latch, 0);
    chk("midrst_an", an, 4'hF);
    chk("midrst_oe_n", oe_n, 1);
    chk("midrst_busy", busy, 0);
    exp_q.delete();
    repeat (2) @(negedge sysclk);
    chk("midrst_no_latch", latch_cnt - base, 0);
    exp_q.push_back({8'h82, 4'b1011});
    #2 rst_n = 1'b1;
    k = 0;
    do begin @(negedge sysclk); k++; end while (!ser_latch && k < 40);
    chk("midrst_refresh_cycle", k, 17);
    repeat (3) @(negedge sysclk);
    chk("midrst_refresh_an", an, 4'b1011);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
